// File: rtl/ccc_phase_step_ctrl.sv
// ccc_phase_step_ctrl: PLL power-up/lock sequencing and phase-step pulse generation.
// Optional PHASE_POS_* position trackers are compiled in with `define CCC_PHASE_TRACK_EN.
module ccc_phase_step_ctrl #(
    parameter int unsigned PD_HOLD_CYCLES      = 16,
    parameter int unsigned LOCK_TIMEOUT        = 65535,
    parameter int unsigned ROTATE_PULSE_CYCLES = 2,
    parameter int unsigned ROTATE_GAP_CYCLES   = 4
) (
    input  logic       SYS_CLK,
    input  logic       SYS_RESET_N,
    input  logic       PLL_LOCK,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [2:0] REQ_OUT_SEL,
    input  logic       REQ_DIR,
    input  logic [5:0] REQ_STEPS,
    output logic       DONE,
    output logic       PLL_READY,
    output logic       LOCK_ERR,
    output logic       PLL_POWERDOWN_N,
    output logic       PHASE_OUT0_SEL,
    output logic       PHASE_OUT2_SEL,
    output logic       PHASE_OUT3_SEL,
    output logic       PHASE_DIRECTION,
    output logic       PHASE_ROTATE,
    output logic       LOAD_PHASE_N
`ifdef CCC_PHASE_TRACK_EN
    ,
    output logic [2:0] PHASE_POS_OUT0,
    output logic [2:0] PHASE_POS_OUT2,
    output logic [2:0] PHASE_POS_OUT3
`endif
);

    localparam int unsigned HW = (PD_HOLD_CYCLES > 1) ? $clog2(PD_HOLD_CYCLES) : 1;
    localparam int unsigned TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int unsigned PMAX = (ROTATE_PULSE_CYCLES > ROTATE_GAP_CYCLES) ?
                                   ROTATE_PULSE_CYCLES : ROTATE_GAP_CYCLES;
    localparam int unsigned PW = (PMAX > 1) ? $clog2(PMAX) : 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(PD_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [PW-1:0] HI_LAST   = PW'(ROTATE_PULSE_CYCLES - 1);
    localparam logic [PW-1:0] LO_LAST   = PW'(ROTATE_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_PD_HOLD,
        S_WAIT_LOCK,
        S_IDLE,
        S_SETUP,
        S_ROT_HI,
        S_ROT_LO,
        S_LOAD
    } state_t;

    state_t state_q, state_d;

    logic          lock_meta, lock_sync;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] to_cnt;
    logic [PW-1:0] rot_cnt;
    logic [2:0]    sel_q, sel_d;
    logic          dir_q, dir_d;
    logic [5:0]    steps_q, steps_d;
    logic          accept, err_set, step_dec;
    logic          win_d, active_d;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge SYS_CLK or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= PLL_LOCK;
            lock_sync <= lock_meta;
        end
    end

    // State register.
    always_ff @(posedge SYS_CLK or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) state_q <= S_PD_HOLD;
        else              state_q <= state_d;
    end

    // Next-state logic; lock loss in any operational state wins over everything.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        err_set  = 1'b0;
        step_dec = 1'b0;
        unique case (state_q)
            S_PD_HOLD: begin
                if (hold_cnt == HOLD_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_sync) begin
                    state_d = S_IDLE;
                end else if (to_cnt == TO_LAST) begin
                    state_d = S_PD_HOLD;
                    err_set = 1'b1;
                end
            end
            S_IDLE: begin
                if (REQ_VALID) begin
                    state_d = S_SETUP;
                    accept  = 1'b1;
                end
            end
            S_SETUP: begin
                state_d = (steps_q == 6'd0) ? S_LOAD : S_ROT_HI;
            end
            S_ROT_HI: begin
                if (rot_cnt == HI_LAST) state_d = S_ROT_LO;
            end
            S_ROT_LO: begin
                if (rot_cnt == LO_LAST) begin
                    step_dec = 1'b1;
                    state_d  = (steps_q == 6'd1) ? S_LOAD : S_ROT_HI;
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_PD_HOLD;
            end
        endcase
        if (state_q inside {S_IDLE, S_SETUP, S_ROT_HI, S_ROT_LO, S_LOAD} &&
            !lock_sync) begin
            state_d  = S_PD_HOLD;
            accept   = 1'b0;
            step_dec = 1'b0;
        end
    end

    // Next values of the latched request; a request with no outputs selected does no steps.
    always_comb begin
        sel_d   = sel_q;
        dir_d   = dir_q;
        steps_d = steps_q;
        if (accept) begin
            sel_d   = REQ_OUT_SEL;
            dir_d   = REQ_DIR;
            steps_d = (REQ_OUT_SEL == 3'd0) ? 6'd0 : REQ_STEPS;
        end else if (step_dec) begin
            steps_d = steps_q - 6'd1;
        end
        win_d    = state_d inside {S_SETUP, S_ROT_HI, S_ROT_LO, S_LOAD};
        active_d = state_d inside {S_IDLE, S_SETUP, S_ROT_HI, S_ROT_LO, S_LOAD};
    end

    // Dwell counters, each cleared whenever its state is entered or left.
    always_ff @(posedge SYS_CLK or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            hold_cnt <= '0;
            to_cnt   <= '0;
            rot_cnt  <= '0;
        end else begin
            hold_cnt <= (state_q == S_PD_HOLD && state_d == S_PD_HOLD) ?
                        hold_cnt + HW'(1) : '0;
            to_cnt   <= (state_q == S_WAIT_LOCK && state_d == S_WAIT_LOCK) ?
                        to_cnt + TW'(1) : '0;
            rot_cnt  <= ((state_q == S_ROT_HI || state_q == S_ROT_LO) &&
                         state_d == state_q) ? rot_cnt + PW'(1) : '0;
        end
    end

    // Latched request fields and remaining-step count.
    always_ff @(posedge SYS_CLK or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            sel_q   <= 3'd0;
            dir_q   <= 1'b0;
            steps_q <= 6'd0;
        end else begin
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            steps_q <= steps_d;
        end
    end

    // Registered outputs, decoded from the next state so they line up with it.
    always_ff @(posedge SYS_CLK or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            PLL_POWERDOWN_N <= 1'b0;
            PHASE_OUT0_SEL  <= 1'b0;
            PHASE_OUT2_SEL  <= 1'b0;
            PHASE_OUT3_SEL  <= 1'b0;
            PHASE_DIRECTION <= 1'b0;
            PHASE_ROTATE    <= 1'b0;
            LOAD_PHASE_N    <= 1'b1;
            REQ_READY       <= 1'b0;
            DONE            <= 1'b0;
            PLL_READY       <= 1'b0;
            LOCK_ERR        <= 1'b0;
        end else begin
            PLL_POWERDOWN_N <= (state_d != S_PD_HOLD);
            PHASE_OUT0_SEL  <= win_d & sel_d[0];
            PHASE_OUT2_SEL  <= win_d & sel_d[1];
            PHASE_OUT3_SEL  <= win_d & sel_d[2];
            PHASE_DIRECTION <= win_d & dir_d;
            PHASE_ROTATE    <= (state_d == S_ROT_HI);
            LOAD_PHASE_N    <= (state_d != S_LOAD);
            REQ_READY       <= (state_d == S_IDLE);
            DONE            <= (state_d == S_LOAD);
            PLL_READY       <= active_d;
            LOCK_ERR        <= LOCK_ERR | err_set;
        end
    end

`ifdef CCC_PHASE_TRACK_EN
    // Modulo-8 phase position per output, stepped at the end of every rotate gap.
    always_ff @(posedge SYS_CLK or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            PHASE_POS_OUT0 <= 3'd0;
            PHASE_POS_OUT2 <= 3'd0;
            PHASE_POS_OUT3 <= 3'd0;
        end else if (state_d == S_PD_HOLD) begin
            PHASE_POS_OUT0 <= 3'd0;
            PHASE_POS_OUT2 <= 3'd0;
            PHASE_POS_OUT3 <= 3'd0;
        end else if (step_dec) begin
            if (sel_q[0]) PHASE_POS_OUT0 <= PHASE_POS_OUT0 + (dir_q ? 3'd1 : 3'd7);
            if (sel_q[1]) PHASE_POS_OUT2 <= PHASE_POS_OUT2 + (dir_q ? 3'd1 : 3'd7);
            if (sel_q[2]) PHASE_POS_OUT3 <= PHASE_POS_OUT3 + (dir_q ? 3'd1 : 3'd7);
        end
    end
`endif

endmodule

// File: tb/tb_ccc_phase_step_ctrl.sv
// tb_ccc_phase_step_ctrl: directed and randomized checks of ccc_phase_step_ctrl
// against a cycle-count and modulo-8 position model.
module tb_ccc_phase_step_ctrl;

    localparam int PD = 16;
    localparam int TO = 100;
    localparam int P  = 2;
    localparam int G  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_sel = 3'd0;
    logic       req_dir = 1'b0;
    logic [5:0] req_steps = 6'd0;

    logic REQ_READY, DONE, PLL_READY, LOCK_ERR, PLL_POWERDOWN_N;
    logic PHASE_OUT0_SEL, PHASE_OUT2_SEL, PHASE_OUT3_SEL;
    logic PHASE_DIRECTION, PHASE_ROTATE, LOAD_PHASE_N;
`ifdef CCC_PHASE_TRACK_EN
    logic [2:0] PHASE_POS_OUT0, PHASE_POS_OUT2, PHASE_POS_OUT3;
`endif

    ccc_phase_step_ctrl #(
        .PD_HOLD_CYCLES(PD),
        .LOCK_TIMEOUT(TO),
        .ROTATE_PULSE_CYCLES(P),
        .ROTATE_GAP_CYCLES(G)
    ) dut (
        .SYS_CLK(clk),
        .SYS_RESET_N(rst_n),
        .PLL_LOCK(pll_lock),
        .REQ_VALID(req_valid),
        .REQ_READY(REQ_READY),
        .REQ_OUT_SEL(req_sel),
        .REQ_DIR(req_dir),
        .REQ_STEPS(req_steps),
        .DONE(DONE),
        .PLL_READY(PLL_READY),
        .LOCK_ERR(LOCK_ERR),
        .PLL_POWERDOWN_N(PLL_POWERDOWN_N),
        .PHASE_OUT0_SEL(PHASE_OUT0_SEL),
        .PHASE_OUT2_SEL(PHASE_OUT2_SEL),
        .PHASE_OUT3_SEL(PHASE_OUT3_SEL),
        .PHASE_DIRECTION(PHASE_DIRECTION),
        .PHASE_ROTATE(PHASE_ROTATE),
        .LOAD_PHASE_N(LOAD_PHASE_N)
`ifdef CCC_PHASE_TRACK_EN
        ,
        .PHASE_POS_OUT0(PHASE_POS_OUT0),
        .PHASE_POS_OUT2(PHASE_POS_OUT2),
        .PHASE_POS_OUT3(PHASE_POS_OUT3)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    int pos_m[3];

    initial begin
        #1000000;
        $display("FAIL global_timeout: got cycle %0d required finish", cyc);
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] sel_bus();
        return {PHASE_OUT3_SEL, PHASE_OUT2_SEL, PHASE_OUT0_SEL};
    endfunction

    function automatic logic [31:0] outs_vec();
        return 32'({PLL_POWERDOWN_N, PHASE_ROTATE, LOAD_PHASE_N,
                    PHASE_OUT3_SEL, PHASE_OUT2_SEL, PHASE_OUT0_SEL,
                    PHASE_DIRECTION, REQ_READY, DONE, PLL_READY, LOCK_ERR});
    endfunction

    task automatic check_pos(input string tag);
`ifdef CCC_PHASE_TRACK_EN
        check({tag, "_pos0"}, 32'(PHASE_POS_OUT0), pos_m[0]);
        check({tag, "_pos2"}, 32'(PHASE_POS_OUT2), pos_m[1]);
        check({tag, "_pos3"}, 32'(PHASE_POS_OUT3), pos_m[2]);
`endif
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (REQ_READY) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic do_req(input logic [2:0] sel, input logic dir,
                          input logic [5:0] steps);
        bit ok;
        bit er;
        logic prev;
        int n, exp_done, done_c, loads, badsel, badrot, pulses;
        wait_ready(ok);
        check("req_ready_wait", 32'(ok), 1);
        if (!ok) return;
        req_valid = 1'b1;
        req_sel   = sel;
        req_dir   = dir;
        req_steps = steps;
        tick();
        req_valid = 1'b0;
        req_sel   = 3'($urandom_range(0, 7));
        req_dir   = 1'($urandom_range(0, 1));
        req_steps = 6'($urandom_range(0, 63));
        n = (sel == 3'd0) ? 0 : int'(steps);
        exp_done = n * (P + G) + 2;
        check("ready_drop", 32'(REQ_READY), 0);
        done_c = 0;
        loads = 0;
        badsel = 0;
        badrot = 0;
        pulses = 0;
        prev = 1'b0;
        for (int c = 1; c <= exp_done + 8 && done_c == 0; c++) begin
            er = (c >= 2) && (c < exp_done) && (((c - 2) % (P + G)) < P);
            if (PHASE_ROTATE !== er) badrot++;
            if (PHASE_ROTATE && !prev) pulses++;
            prev = PHASE_ROTATE;
            if (sel_bus() !== sel || PHASE_DIRECTION !== dir) badsel++;
            if (!LOAD_PHASE_N) loads++;
            if (DONE) done_c = c;
            else tick();
        end
        check("done_cycle", done_c, exp_done);
        check("rot_wave", badrot, 0);
        check("rot_pulses", pulses, n);
        check("load_n_low", loads, 1);
        check("sel_hold", badsel, 0);
        tick();
        check("ready_back", 32'(REQ_READY), 1);
        check("done_width", 32'(DONE), 0);
        check("sel_release", 32'({PHASE_DIRECTION, sel_bus(), LOAD_PHASE_N}), 1);
        for (int i = 0; i < 3; i++)
            if (sel[i]) pos_m[i] = (pos_m[i] + (dir ? n : 512 - n)) % 8;
        check_pos("req");
    endtask

    initial begin
        bit ok;
        bit seen;
        int t0, t1;
        for (int i = 0; i < 3; i++) pos_m[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", outs_vec(), 32'h100);
        check_pos("rst");

        @(negedge clk);
        rst_n = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (PLL_POWERDOWN_N) break;
        end
        check("pwrup_cycle", cyc - t0, PD);
        check("pwrup_not_ready", 32'(PLL_READY), 0);
        while (cyc - t0 < 40) tick();
        pll_lock = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (PLL_READY) break;
        end
        check("lock_ready_cycle", cyc - t0, 43);
        check("lock_err_clear", 32'(LOCK_ERR), 0);

        do_req(3'b110, 1'b0, 6'd1);
        do_req(3'b001, 1'b1, 6'd3);
        do_req(3'b101, 1'b1, 6'd0);
        do_req(3'b000, 1'b1, 6'd5);
        do_req(3'b111, 1'b1, 6'd63);
        for (int k = 0; k < 10; k++)
            do_req(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   6'($urandom_range(0, 10)));

        wait_ready(ok);
        check("abort_ready", 32'(ok), 1);
        req_valid = 1'b1;
        req_sel   = 3'b001;
        req_dir   = 1'b1;
        req_steps = 6'd5;
        tick();
        req_valid = 1'b0;
        repeat (7) tick();
        check("abort_in_rot_hi", 32'(PHASE_ROTATE), 1);
        pll_lock = 1'b0;
        t1 = cyc;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (DONE) seen = 1'b1;
            if (!PLL_POWERDOWN_N) break;
        end
        check("abort_latency", cyc - t1, 3);
        check("abort_no_done", 32'(seen), 0);
        check("abort_outs", 32'({PHASE_ROTATE, sel_bus(), LOAD_PHASE_N,
                                 REQ_READY, PLL_READY}), 32'b0000100);
        for (int i = 0; i < 3; i++) pos_m[i] = 0;
        check_pos("abort");

        pll_lock = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (PLL_READY) break;
        end
        check("relock_ready", 32'(PLL_READY), 1);
        do_req(3'b010, 1'b1, 6'd2);

        pll_lock = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!PLL_POWERDOWN_N) break;
        end
        for (int i = 0; i < 3; i++) pos_m[i] = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (PLL_POWERDOWN_N) break;
        end
        t1 = cyc;
        check("to_err_before", 32'(LOCK_ERR), 0);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (LOCK_ERR) break;
        end
        check("to_err_cycle", cyc - t1, TO);
        check("to_pd_low", 32'(PLL_POWERDOWN_N), 0);
        t1 = cyc;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (PLL_POWERDOWN_N) break;
        end
        check("to_pd_pulse", cyc - t1, PD);
        pll_lock = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (PLL_READY) break;
        end
        check("to_relock_ready", 32'(PLL_READY), 1);
        check("to_err_sticky", 32'(LOCK_ERR), 1);
        do_req(3'b011, 1'b0, 6'd9);

        wait_ready(ok);
        req_valid = 1'b1;
        req_sel   = 3'b111;
        req_dir   = 1'b1;
        req_steps = 6'd4;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", outs_vec(), 32'h100);
        for (int i = 0; i < 3; i++) pos_m[i] = 0;
        check_pos("async_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
